ks_mp_add_seq: RTL and testbench

//  Multi-precision add/subtract sequencer around one 16-bit Kogge-Stone adder slice.

---
 rtl/ks_mp_add_seq_pkg.sv | 16 +
 rtl/ks_adder_16bit_ci.sv | 63 ++++++
 rtl/ks_mp_add_seq.sv | 103 ++++++++++
 tb/tb_ks_mp_add_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ks_mp_add_seq_pkg.sv
// Shared constants and types for the multi-precision Kogge-Stone add/sub sequencer.
package ks_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width);
        return width / CHUNK_W;
    endfunction

endpackage

// File: rtl/ks_adder_16bit_ci.sv
// 16-bit Kogge-Stone prefix adder with carry-in; s[16] is the carry out.
module ks_adder_16bit_ci (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [16:0] s
);

    logic [15:0] hp, g0, g1, g2, g3, g4;
    // Group propagates are only kept for the bit positions a later level reads.
    logic [15:2] p1;
    logic [15:4] p2;
    logic [15:8] p3;

    assign hp = a ^ b;
    // Carry-in is folded into bit 0 so the prefix tree yields carries that include it.
    assign g0 = {a[15:1] & b[15:1], (a[0] & b[0]) | (hp[0] & cin)};

    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_lvl1
            if (i >= 1) begin : g_c
                assign g1[i] = g0[i] | (hp[i] & g0[i-1]);
            end else begin : g_p
                assign g1[i] = g0[i];
            end
            if (i >= 2) begin : g_pp
                assign p1[i] = hp[i] & hp[i-1];
            end
        end
        for (i = 0; i < 16; i++) begin : g_lvl2
            if (i >= 2) begin : g_c
                assign g2[i] = g1[i] | (p1[i] & g1[i-2]);
            end else begin : g_p
                assign g2[i] = g1[i];
            end
            if (i >= 4) begin : g_pp
                assign p2[i] = p1[i] & p1[i-2];
            end
        end
        for (i = 0; i < 16; i++) begin : g_lvl3
            if (i >= 4) begin : g_c
                assign g3[i] = g2[i] | (p2[i] & g2[i-4]);
            end else begin : g_p
                assign g3[i] = g2[i];
            end
            if (i >= 8) begin : g_pp
                assign p3[i] = p2[i] & p2[i-4];
            end
        end
        for (i = 0; i < 16; i++) begin : g_lvl4
            if (i >= 8) begin : g_c
                assign g4[i] = g3[i] | (p3[i] & g3[i-8]);
            end else begin : g_p
                assign g4[i] = g3[i];
            end
        end
    endgenerate

    assign s[15:0] = hp ^ {g4[14:0], cin};
    assign s[16]   = g4[15];

endmodule

// File: rtl/ks_mp_add_seq.sv
// Multi-precision add/subtract: one 16-bit Kogge-Stone slice reused chunk by chunk,
// LSB first, with the carry registered between chunks.
module ks_mp_add_seq
    import ks_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    localparam int NCHUNK = nchunk(WIDTH);
    localparam int IDX_W  = $clog2(NCHUNK);

    state_t                          state;
    logic [NCHUNK-1:0][CHUNK_W-1:0]  a_r, b_r, sum_r;
    logic                            carry;
    logic [IDX_W-1:0]                idx;
    logic [CHUNK_W:0]                s;
    logic                            last_chunk;

    ks_adder_16bit_ci u_slice (
        .a   (a_r[idx]),
        .b   (b_r[idx]),
        .cin (carry),
        .s   (s)
    );

    assign out_sum    = sum_r;
    assign last_chunk = (idx == IDX_W'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
            op_cnt    <= '0;
            a_r       <= '0;
            b_r       <= '0;
            sum_r     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtract is A + ~B + 1: invert B once here, seed the carry.
                        a_r      <= in_a;
                        b_r      <= in_b ^ {WIDTH{in_sub}};
                        carry    <= in_sub;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_r[idx] <= s[CHUNK_W-1:0];
                    carry      <= s[CHUNK_W];
                    idx        <= idx + 1'b1;
                    if (last_chunk) begin
                        out_cout  <= s[CHUNK_W];
                        out_ovf   <= (a_r[NCHUNK-1][CHUNK_W-1] == b_r[NCHUNK-1][CHUNK_W-1]) &&
                                     (s[CHUNK_W-1] != a_r[NCHUNK-1][CHUNK_W-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_cnt    <= op_cnt + 1'b1;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ks_mp_add_seq.sv
// Scoreboard bench for ks_mp_add_seq (WIDTH=64): directed corner ops, backpressure,
// mid-op reset and a random sweep against an arithmetic reference model.
module tb_ks_mp_add_seq;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_sub;
    logic [63:0] in_a, in_b;
    logic        out_valid, out_ready, out_cout, out_ovf, busy;
    logic [63:0] out_sum;
    logic [15:0] op_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [15:0] exp_cnt;

    ks_mp_add_seq #(.WIDTH(64), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [63:0] a, input logic [63:0] b, input logic sub);
        exp_t        e;
        logic [64:0] r;
        if (sub) r = {1'b0, a} - {1'b0, b};
        else     r = {1'b0, a} + {1'b0, b};
        e.sum  = r[63:0];
        // No borrow on subtract means carry out = 1.
        e.cout = sub ? (a >= b) : r[64];
        if (sub) e.ovf = (a[63] != b[63]) && (r[63] != a[63]);
        else     e.ovf = (a[63] == b[63]) && (r[63] != a[63]);
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every result that is actually handed off.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %h with no expected entry", out_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_sum", out_sum, e.sum);
                check("out_cout", 64'(out_cout), 64'(e.cout));
                check("out_ovf", 64'(out_ovf), 64'(e.ovf));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input int hold);
        int n;
        logic [15:0] cnt0;
        exp_t e;
        wait_ready();
        e         = model(a, b, sub);
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            if (!busy) check("busy_run", 64'(busy), 64'd1);
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'd4);
        cnt0 = op_cnt;
        if (hold > 0) begin
            in_valid = 1'b1;
            in_a     = {$urandom, $urandom};
            in_b     = {$urandom, $urandom};
            in_sub   = 1'($urandom);
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #1;
                check("bp_valid", 64'(out_valid), 64'd1);
                check("bp_sum", out_sum, e.sum);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_op_cnt", 64'(op_cnt), 64'(cnt0));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        exp_cnt++;
        check("op_cnt", 64'(op_cnt), 64'(exp_cnt));
        check("post_valid", 64'(out_valid), 64'd0);
        check("post_in_ready", 64'(in_ready), 64'd1);
        check("post_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        exp_cnt   = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_sum", out_sum, 64'd0);
        check("rst_cout_ovf", {62'd0, out_cout, out_ovf}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_cnt", 64'(op_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run_op(64'h0000_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
        run_op(64'd1, 64'd2, 1'b1, 0);
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 0);
        run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 5);

        // Reset after two RUN cycles: the op in flight is dropped.
        wait_ready();
        in_a = 64'hDEAD_BEEF_0000_1111; in_b = 64'h2222; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_op_cnt", 64'(op_cnt), 64'd0);
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        run_op(64'h1021_48A0_24C1_ABC1, 64'hF02F_F50D_111F_01BF, 1'b0, 0);

        for (int i = 0; i < 1000; i++) begin
            logic [63:0] a, b;
            int          h;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) a[63:32] = 32'hFFFF_FFFF;
            if ($urandom_range(0, 7) == 0) b = ~a;
            h = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
            run_op(a, b, 1'($urandom), h);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
